taillight_seq: RTL and testbench

Sequencer for the tail-light lamp banks. Takes the 3-bit light-state code from the next-state logic, registers it, and runs a prescaled phase counter. Drives three lamps per side: sequential turn sweep, hazard flash, steady brake and idle. Sits between the next-state decoder and the LED pins. It is the only block that owns lamp timing.

---
 rtl/taillight_seq_pkg.sv | 28 ++
 rtl/taillight_seq_tick_gen.sv | 30 +++
 rtl/taillight_seq.sv | 86 ++++++++
 tb/tb_taillight_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/taillight_seq_pkg.sv
// Shared light-state codes, lamp pattern constants and the sequential sweep table
// for the tail-light sequencer.
package taillight_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HZRD      = 3'd1,
    BRK       = 3'd2,
    SIG_L     = 3'd3,
    SIG_R     = 3'd4,
    BRK_SIG_L = 3'd5,
    BRK_SIG_R = 3'd6
  } light_state_e;

  localparam logic [2:0] PAT_OFF = '0;
  localparam logic [2:0] PAT_ON  = '1;

  // Bit0 is the inner lamp, so the sweep fills from the inside outwards.
  function automatic logic [2:0] sweep(input logic [1:0] phase);
    case (phase)
      2'd0:    sweep = 3'b000;
      2'd1:    sweep = 3'b001;
      2'd2:    sweep = 3'b011;
      default: sweep = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/taillight_seq_tick_gen.sv
// Animation prescaler: counts TICK_DIV clocks and flags the last count of each period.
// The flag is combinational so the owner can update its registers on that same edge.
module tick_gen #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  // A state change restarts the period, so it also masks a coincident terminal count.
  assign tick   = w_last && !clr;

  always_ff @(posedge clk) begin
    if (rst || clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/taillight_seq.sv
// Tail-light sequencer: registers the light-state code, runs the animation phase
// and drives the registered left/right lamp banks.
module taillight_seq
  import taillight_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] next_state,
  output logic [2:0] current_state,
  output logic       step,
  output logic [2:0] lamp_l,
  output logic [2:0] lamp_r
);

  logic       w_change;
  logic       w_tick;
  logic [1:0] r_phase;
  logic [2:0] w_lamp_l;
  logic [2:0] w_lamp_r;

  assign w_change = (next_state != current_state);

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_change),
    .tick (w_tick)
  );

  always_comb begin
    w_lamp_l = PAT_OFF;
    w_lamp_r = PAT_OFF;
    case (current_state)
      HZRD: begin
        w_lamp_l = r_phase[0] ? PAT_ON : PAT_OFF;
        w_lamp_r = r_phase[0] ? PAT_ON : PAT_OFF;
      end
      BRK: begin
        w_lamp_l = PAT_ON;
        w_lamp_r = PAT_ON;
      end
      SIG_L:     w_lamp_l = sweep(r_phase);
      SIG_R:     w_lamp_r = sweep(r_phase);
      BRK_SIG_L: begin
        w_lamp_l = sweep(r_phase);
        w_lamp_r = PAT_ON;
      end
      BRK_SIG_R: begin
        w_lamp_l = PAT_ON;
        w_lamp_r = sweep(r_phase);
      end
      default: begin
        w_lamp_l = PAT_OFF;
        w_lamp_r = PAT_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      current_state <= IDLE;
      r_phase       <= '0;
      step          <= 1'b0;
      lamp_l        <= PAT_OFF;
      lamp_r        <= PAT_OFF;
    end else begin
      current_state <= next_state;
      lamp_l        <= w_lamp_l;
      lamp_r        <= w_lamp_r;
      if (w_change) begin
        r_phase <= '0;
        step    <= 1'b0;
      end else begin
        step <= w_tick;
        if (w_tick) r_phase <= r_phase + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_taillight_seq.sv
// Scoreboard bench for taillight_seq: a driver pushes the expected per-edge outputs,
// a monitor pops and compares them after every rising edge.
module tb_taillight_seq;
  import taillight_seq_pkg::*;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] next_state = 3'd0;
  logic [2:0] current_state;
  logic       step;
  logic [2:0] lamp_l;
  logic [2:0] lamp_r;

  taillight_seq #(
    .TICK_DIV (TD),
    .CNT_W    (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .next_state    (next_state),
    .current_state (current_state),
    .step          (step),
    .lamp_l        (lamp_l),
    .lamp_r        (lamp_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       stp;
    logic [2:0] l;
    logic [2:0] r;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: state seen by the block, and edges elapsed since the last restart
  // (reset or state change). Phase and step follow arithmetically from that.
  int   m_state = 0;
  int   m_since = 0;

  function automatic void pattern(input int st, input int ph,
                                  output logic [2:0] l, output logic [2:0] r);
    logic [2:0] sw;
    logic [2:0] hz;
    sw = 3'((1 << ph) - 1);
    hz = (ph % 2 == 1) ? 3'd7 : 3'd0;
    case (st)
      1:       begin l = hz;   r = hz;   end
      2:       begin l = 3'd7; r = 3'd7; end
      3:       begin l = sw;   r = 3'd0; end
      4:       begin l = 3'd0; r = sw;   end
      5:       begin l = sw;   r = 3'd7; end
      6:       begin l = 3'd7; r = sw;   end
      default: begin l = 3'd0; r = 3'd0; end
    endcase
  endfunction

  function automatic int m_phase();
    return (m_since / TD) % 4;
  endfunction

  task automatic apply(input bit r_in, input logic [2:0] ns);
    exp_t e;
    if (r_in) begin
      e.l = 3'd0;
      e.r = 3'd0;
    end else begin
      pattern(m_state, m_phase(), e.l, e.r);
    end
    if (r_in) begin
      m_state = 0;
      m_since = 0;
      e.stp   = 1'b0;
    end else if (int'(ns) != m_state) begin
      m_state = int'(ns);
      m_since = 0;
      e.stp   = 1'b0;
    end else begin
      m_since++;
      e.stp = (m_since % TD == 0);
    end
    e.st = 3'(m_state);
    q.push_back(e);
    rst        = r_in;
    next_state = ns;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: the DUT presents a fresh output set after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("current_state", int'(current_state), int'(e.st));
        chk("step",          int'(step),          int'(e.stp));
        chk("lamp_l",        int'(lamp_l),        int'(e.l));
        chk("lamp_r",        int'(lamp_r),        int'(e.r));
      end
    end
  end

  initial begin
    int         k;
    int         len;
    bit         r;
    logic [2:0] ns;

    // Reset held with SIG_L present, then a full sweep with wrap.
    repeat (3) apply(1'b1, SIG_L);
    repeat (22) apply(1'b0, SIG_L);

    // Brake latency and steadiness.
    repeat (3) apply(1'b0, IDLE);
    repeat (20) apply(1'b0, BRK);

    // Hazard alternation.
    repeat (20) apply(1'b0, HZRD);

    // Mid-sweep change on the right, then swap the turn side.
    k = 0;
    while (m_phase() != 2 && k < 40) begin apply(1'b0, SIG_R); k++; end
    apply(1'b0, SIG_R);
    repeat (6) apply(1'b0, BRK_SIG_R);
    repeat (10) apply(1'b0, BRK_SIG_L);

    // State change coincident with the terminal prescaler count.
    k = 0;
    while (m_since % TD != TD - 1 && k < 40) begin apply(1'b0, SIG_L); k++; end
    repeat (9) apply(1'b0, SIG_R);

    // Unlisted code, then reset mid-sweep.
    repeat (8) apply(1'b0, 3'b111);
    k = 0;
    while (m_phase() != 2 && k < 40) begin apply(1'b0, SIG_L); k++; end
    apply(1'b1, SIG_L);
    repeat (14) apply(1'b0, SIG_L);

    // One-cycle glitch restarts the sweep.
    repeat (9) apply(1'b0, SIG_L);
    apply(1'b0, IDLE);
    repeat (10) apply(1'b0, SIG_L);

    // Randomized holds, occasional reset.
    repeat (60) begin
      ns  = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 12);
      r   = ($urandom_range(0, 15) == 0);
      apply(r, ns);
      repeat (len - 1) apply(1'b0, ns);
    end

    @(posedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
